// File: rtl/dmem_pkg.sv
// Shared types, funct3 codes and access-legality helpers
// for the data-memory load/store controller.
package dmem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RD_WAIT,
        WR,
        RESP
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef struct packed {
        logic        we;
        logic [2:0]  funct3;
        logic [1:0]  lane;
        logic [31:0] wdata;
    } req_t;

    function automatic logic misaligned(
        input logic [2:0] f3,
        input logic [1:0] lane
    );
        logic bad;
        bad = 1'b0;
        unique case (f3[1:0])
            2'b01:   bad = lane[0];
            2'b10:   bad = (lane != 2'd0);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

    function automatic logic f3_legal(
        input logic       we,
        input logic [2:0] f3
    );
        logic ok;
        ok = 1'b0;
        unique case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = !we;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Lane extraction with sign/zero extension for loads and
// byte/half merge of store data into a read word.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    output logic [31:0] load_val,
    output logic [31:0] merged
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b = word[7:0];
        unique case (lane)
            2'd0: b = word[7:0];
            2'd1: b = word[15:8];
            2'd2: b = word[23:16];
            2'd3: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        load_val = word;
        unique case (funct3)
            F3_B:    load_val = {{24{b[7]}}, b};
            F3_BU:   load_val = {24'd0, b};
            F3_H:    load_val = {{16{h[15]}}, h};
            F3_HU:   load_val = {16'd0, h};
            default: load_val = word;
        endcase
    end

    // Only the addressed lane comes from wdata.
    always_comb begin
        merged = word;
        if (funct3[1:0] == 2'b00) begin
            unique case (lane)
                2'd0: merged[7:0]   = wdata[7:0];
                2'd1: merged[15:8]  = wdata[7:0];
                2'd2: merged[23:16] = wdata[7:0];
                2'd3: merged[31:24] = wdata[7:0];
            endcase
        end else if (funct3[1:0] == 2'b01) begin
            if (lane[1])
                merged[31:16] = wdata[15:0];
            else
                merged[15:0] = wdata[15:0];
        end
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Byte-addressed RV32I load/store controller driving a
// word-wide synchronous RAM, with read-modify-write stores.
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int RAM_DATA = 32,
    parameter int RAM_ADD  = 10
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                REQ,
    input  logic                WE,
    input  logic [2:0]          FUNCT3,
    input  logic [31:0]         ADDR,
    input  logic [31:0]         WDATA,
    output logic [RAM_DATA-1:0] RDATA,
    output logic                READY,
    output logic                ERROR,
    output logic                BUSY,
    output logic [RAM_ADD-1:0]  MEM_ADDRESS,
    output logic [RAM_DATA-1:0] MEM_DATA_IN,
    input  logic [RAM_DATA-1:0] MEM_DATA_OUT,
    output logic                MEM_READ,
    output logic                MEM_WRITE
);

    state_t              state;
    state_t              nxt;
    req_t                req_q;
    logic                err_q;
    logic                req_err;
    logic                is_sw;
    logic [31:0]         load_val;
    logic [31:0]         merged;
    logic [RAM_DATA-1:0] rdata_q;
    logic [RAM_ADD-1:0]  addr_q;
    logic [RAM_DATA-1:0] din_q;
    logic                unused_addr;

    assign unused_addr = ^ADDR[31:RAM_ADD+2];

    assign req_err = !f3_legal(WE, FUNCT3)
                   || misaligned(FUNCT3, ADDR[1:0]);
    assign is_sw   = WE && (FUNCT3 == F3_W);

    dmem_lane_align u_align (
        .word     (MEM_DATA_OUT),
        .lane     (req_q.lane),
        .funct3   (req_q.funct3),
        .wdata    (req_q.wdata),
        .load_val (load_val),
        .merged   (merged)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            state <= IDLE;
        else
            state <= nxt;
    end

    always_comb begin
        nxt       = state;
        MEM_READ  = 1'b0;
        MEM_WRITE = 1'b0;
        READY     = 1'b0;
        ERROR     = 1'b0;
        BUSY      = (state != IDLE);
        unique case (state)
            IDLE: begin
                if (REQ) begin
                    if (req_err)
                        nxt = RESP;
                    else if (is_sw)
                        nxt = WR;
                    else
                        nxt = RD;
                end
            end
            RD: begin
                MEM_READ = 1'b1;
                nxt      = RD_WAIT;
            end
            RD_WAIT: begin
                nxt = req_q.we ? WR : RESP;
            end
            WR: begin
                MEM_WRITE = 1'b1;
                nxt       = RESP;
            end
            RESP: begin
                READY = 1'b1;
                ERROR = err_q;
                nxt   = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    // Request capture and the registered datapath outputs.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            req_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            addr_q  <= '0;
            din_q   <= '0;
        end else begin
            if (state == IDLE && REQ) begin
                req_q.we     <= WE;
                req_q.funct3 <= FUNCT3;
                req_q.lane   <= ADDR[1:0];
                req_q.wdata  <= WDATA;
                err_q        <= req_err;
                addr_q       <= ADDR[RAM_ADD+1:2];
                if (req_err)
                    rdata_q <= '0;
                else if (is_sw)
                    din_q <= WDATA;
            end
            if (state == RD_WAIT) begin
                if (req_q.we)
                    din_q <= merged;
                else
                    rdata_q <= load_val;
            end
        end
    end

    assign RDATA       = rdata_q;
    assign MEM_ADDRESS = addr_q;
    assign MEM_DATA_IN = din_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed and random checks of dmem_access_ctrl against
// an arithmetic model of RV32I load/store semantics.
module tb_dmem_access_ctrl;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        REQ = 1'b0;
    logic        WE = 1'b0;
    logic [2:0]  FUNCT3 = 3'd0;
    logic [31:0] ADDR = 32'd0;
    logic [31:0] WDATA = 32'd0;
    logic [31:0] RDATA;
    logic        READY;
    logic        ERROR;
    logic        BUSY;
    logic [9:0]  MEM_ADDRESS;
    logic [31:0] MEM_DATA_IN;
    logic [31:0] MEM_DATA_OUT;
    logic        MEM_READ;
    logic        MEM_WRITE;

    dmem_access_ctrl #(.RAM_DATA(32), .RAM_ADD(10)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .REQ          (REQ),
        .WE           (WE),
        .FUNCT3       (FUNCT3),
        .ADDR         (ADDR),
        .WDATA        (WDATA),
        .RDATA        (RDATA),
        .READY        (READY),
        .ERROR        (ERROR),
        .BUSY         (BUSY),
        .MEM_ADDRESS  (MEM_ADDRESS),
        .MEM_DATA_IN  (MEM_DATA_IN),
        .MEM_DATA_OUT (MEM_DATA_OUT),
        .MEM_READ     (MEM_READ),
        .MEM_WRITE    (MEM_WRITE)
    );

    always #5 CLK = ~CLK;

    logic [31:0] ram [1024];
    logic [31:0] ref_mem [1024];
    logic [31:0] mem_q;

    assign MEM_DATA_OUT = mem_q;

    always @(posedge CLK) begin
        if (MEM_WRITE)
            ram[MEM_ADDRESS] <= MEM_DATA_IN;
        if (MEM_READ)
            mem_q <= ram[MEM_ADDRESS];
    end

    int n_assert = 0;
    int n_fail = 0;

    int          lat, rd_cnt, wr_cnt, rd_at, wr_at, rdy_cnt;
    logic [31:0] rd_addr, wr_addr, wr_data, got_rdata;
    logic        got_err, both, found;
    logic [31:0] model_rdata;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h",
                   tag, obs, exp);
        end
    endtask

    function automatic bit m_err(input bit we, input int f3,
                                 input logic [31:0] a);
        bit ok;
        int n;
        if (we)
            ok = (f3 <= 2);
        else
            ok = (f3 inside {0, 1, 2, 4, 5});
        n = 1 << (f3 % 4);
        return !ok || ((int'(a[2:0]) % n) != 0);
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] w,
                                           input int lane,
                                           input int f3);
        int unsigned v;
        if (f3 == 0 || f3 == 4) begin
            v = (w >> (8 * lane)) & 255;
            if (f3 == 0 && v >= 128)
                v = v + 32'hFFFF_FF00;
        end else if (f3 == 1 || f3 == 5) begin
            v = (w >> (16 * (lane / 2))) & 65535;
            if (f3 == 1 && v >= 32768)
                v = v + 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] m_merge(input logic [31:0] w,
                                            input int lane,
                                            input int f3,
                                            input logic [31:0] wd);
        logic [31:0] mask;
        int sh;
        if (f3 == 2)
            return wd;
        if (f3 == 0) begin
            sh = 8 * lane;
            mask = 32'hFF;
        end else begin
            sh = 16 * (lane / 2);
            mask = 32'hFFFF;
        end
        return (w & ~(mask << sh)) | ((wd & mask) << sh);
    endfunction

    task automatic access(input bit we, input int f3,
                          input logic [31:0] a,
                          input logic [31:0] wd);
        @(negedge CLK);
        REQ = 1'b1;
        WE = we;
        FUNCT3 = 3'(f3);
        ADDR = a;
        WDATA = wd;
        @(posedge CLK);
        #1 REQ = 1'b0;
        lat = 0; rd_cnt = 0; wr_cnt = 0;
        rd_at = 0; wr_at = 0; both = 1'b0;
        got_err = 1'bx;
        got_rdata = 32'hx;
        for (int k = 1; k <= 10; k++) begin
            @(negedge CLK);
            if (MEM_READ) begin
                rd_cnt++;
                rd_at = k;
                rd_addr = 32'(MEM_ADDRESS);
            end
            if (MEM_WRITE) begin
                wr_cnt++;
                wr_at = k;
                wr_addr = 32'(MEM_ADDRESS);
                wr_data = MEM_DATA_IN;
            end
            if (MEM_READ && MEM_WRITE)
                both = 1'b1;
            if (READY) begin
                lat = k;
                got_rdata = RDATA;
                got_err = ERROR;
                break;
            end
        end
    endtask

    task automatic run(input bit we, input int f3,
                       input logic [31:0] a,
                       input logic [31:0] wd);
        bit e;
        int idx, lane, xl;
        logic [31:0] nw;
        e = m_err(we, f3, a);
        idx = int'(a[11:2]);
        lane = int'(a[1:0]);
        access(we, f3, a, wd);
        xl = e ? 1 : (!we ? 3 : (f3 == 2 ? 2 : 4));
        chk("latency", lat, xl);
        chk("error", 32'(got_err), 32'(e));
        chk("strobe_overlap", 32'(both), 0);
        chk("read_count", rd_cnt,
            (!e && !(we && f3 == 2)) ? 1 : 0);
        chk("write_count", wr_cnt, (!e && we) ? 1 : 0);
        if (!e && !(we && f3 == 2)) begin
            chk("read_cycle", rd_at, 1);
            chk("read_addr", rd_addr, idx);
        end
        if (e) begin
            model_rdata = 32'd0;
        end else if (we) begin
            nw = m_merge(ref_mem[idx], lane, f3, wd);
            chk("write_cycle", wr_at, f3 == 2 ? 1 : 3);
            chk("write_addr", wr_addr, idx);
            chk("write_data", wr_data, nw);
            ref_mem[idx] = nw;
        end else begin
            model_rdata = m_load(ref_mem[idx], lane, f3);
        end
        chk("rdata", got_rdata, model_rdata);
        @(negedge CLK);
        chk("ready_pulse", 32'(READY), 0);
        chk("idle_busy", 32'(BUSY), 0);
        chk("ram_word", ram[idx], ref_mem[idx]);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            ram[i] = $urandom;
            ref_mem[i] = ram[i];
        end
        ram[5] = 32'h8899_AABB;
        ram[2] = 32'h1122_3344;
        ram[16] = 32'hCAFE_0016;
        ram[17] = 32'hCAFE_0017;
        for (int i = 0; i < 32; i++)
            ref_mem[i] = ram[i];
        model_rdata = 32'd0;

        #1;
        chk("rst_rdata", RDATA, 0);
        chk("rst_ready", 32'(READY), 0);
        chk("rst_error", 32'(ERROR), 0);
        chk("rst_busy", 32'(BUSY), 0);
        chk("rst_addr", 32'(MEM_ADDRESS), 0);
        chk("rst_din", MEM_DATA_IN, 0);
        chk("rst_rd", 32'(MEM_READ), 0);
        chk("rst_wr", 32'(MEM_WRITE), 0);
        repeat (2) @(negedge CLK);
        RESET = 1'b0;

        run(0, 0, 32'h15, 32'h0);
        chk("lb_value", got_rdata, 32'hFFFF_FFAA);
        run(0, 4, 32'h15, 32'h0);
        chk("lbu_value", got_rdata, 32'h0000_00AA);
        run(1, 1, 32'h0A, 32'h0000_BEEF);
        chk("sh_merge", wr_data, 32'hBEEF_3344);
        run(1, 2, 32'h0C, 32'hDEAD_BEEF);
        chk("sw_addr", wr_addr, 3);
        run(0, 2, 32'h0C, 32'h0);
        chk("lw_value", got_rdata, 32'hDEAD_BEEF);
        run(0, 2, 32'h06, 32'h0);
        run(1, 1, 32'h03, 32'h1234);
        run(0, 3, 32'h10, 32'h0);
        run(0, 1, 32'h8000_0016, 32'h0);

        // Reset in the middle of an SB write cycle.
        @(negedge CLK);
        REQ = 1'b1; WE = 1'b1; FUNCT3 = 3'd0;
        ADDR = 32'h21; WDATA = 32'h55;
        @(posedge CLK);
        #1 REQ = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 6 && !found; k++) begin
            @(negedge CLK);
            if (MEM_WRITE) found = 1'b1;
        end
        chk("rmw_reached_wr", 32'(found), 1);
        #1 RESET = 1'b1;
        #1;
        chk("rst_wr_drop", 32'(MEM_WRITE), 0);
        chk("rst_busy_drop", 32'(BUSY), 0);
        chk("rst_no_ready", 32'(READY), 0);
        chk("rst_rdata_clr", RDATA, 0);
        model_rdata = 32'd0;
        @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        rdy_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            if (READY) rdy_cnt++;
        end
        chk("rst_ready_cnt", rdy_cnt, 0);
        chk("rst_ram_kept", ram[8], ref_mem[8]);

        // REQ held high with a changing address while busy.
        @(negedge CLK);
        REQ = 1'b1; WE = 1'b0; FUNCT3 = 3'd2;
        ADDR = 32'h40; WDATA = 32'h0;
        @(posedge CLK);
        #1 ADDR = 32'h44;
        rdy_cnt = 0;
        rd_addr = 32'hx;
        got_rdata = 32'hx;
        for (int k = 1; k <= 10; k++) begin
            @(negedge CLK);
            if (k == 1)
                chk("hold_busy", 32'(BUSY), 1);
            if (MEM_READ) rd_addr = 32'(MEM_ADDRESS);
            if (READY) begin
                rdy_cnt++;
                got_rdata = RDATA;
                REQ = 1'b0;
            end
        end
        REQ = 1'b0;
        chk("hold_ready_cnt", rdy_cnt, 1);
        chk("hold_read_addr", rd_addr, 16);
        model_rdata = ref_mem[16];
        chk("hold_rdata", got_rdata, model_rdata);

        for (int i = 0; i < 60; i++) begin
            bit rwe;
            int rf3;
            logic [31:0] ra;
            rwe = 1'($urandom_range(0, 1));
            rf3 = $urandom_range(0, 7);
            ra = $urandom & 32'hFFFF_F03F;
            run(rwe, rf3, ra, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Load/store controller between CORE's data-memory port and the word-wide RAM.
- Converts byte-addressed RV32I accesses (LB/LH/LW/LBU/LHU/SB/SH/SW) into word-addressed RAM cycles.
- Sub-word loads: extracts the selected lane and sign/zero extends it.
- Sub-word stores: performs read-modify-write.
- Misaligned or illegal accesses return an error response without touching RAM.

Parameters:
- RAM_DATA, 32, data word width; fixed at 32 for RV32.
- RAM_ADD, 10, RAM word-address width.

Ports:
- CLK, input, 1: clock, rising edge.
- RESET, input, 1: asynchronous, active-high reset.
- REQ, input, 1: core access request; sampled only in IDLE.
- WE, input, 1: 1 = store, 0 = load.
- FUNCT3, input, 3: RV32I funct3 (size and signedness).
- ADDR, input, 32: byte address.
- WDATA, input, 32: store data; the lane is taken from its LSBs.
- RDATA, output, 32: load result, valid while READY=1.
- READY, output, 1: one-cycle completion pulse.
- ERROR, output, 1: qualifies READY; access was rejected.
- BUSY, output, 1: high in every state except IDLE.
- MEM_ADDRESS, output, RAM_ADD: RAM word address.
- MEM_DATA_IN, output, 32: write data to RAM.
- MEM_DATA_OUT, input, 32: read data from RAM; valid the cycle after MEM_READ.
- MEM_READ, output, 1: RAM read strobe.
- MEM_WRITE, output, 1: RAM write strobe; written on that clock edge.

Behaviour:
- Reset:
  - All outputs go to 0 and the state goes to IDLE, asynchronously.
  - Reset during any state aborts the access. A pending RMW write is dropped and no READY is issued.
- Request capture:
  - In IDLE with REQ=1, latch ADDR, FUNCT3, WE and WDATA.
  - REQ in any other state is ignored. The core waits for READY before issuing again.
- Address mapping:
  - Word index = ADDR[RAM_ADD+1:2]; upper bits are ignored (wrap).
  - Lane = ADDR[1:0].
- Legality checks:
  - Legal load FUNCT3: 000, 001, 010, 100, 101.
  - Legal store FUNCT3: 000, 001, 010.
  - Misaligned: halfword with ADDR[0]=1, or word with ADDR[1:0]≠0.
  - An illegal or misaligned request goes IDLE→RESP with ERROR=1, RDATA=0, and no MEM_READ/MEM_WRITE.
- States:
  - IDLE → RD (load, or SB/SH) | WR (SW) | RESP (error).
  - RD: MEM_READ=1, MEM_ADDRESS=word index → RD_WAIT.
  - RD_WAIT: capture MEM_DATA_OUT.
    - Load: extract lane, extend, register into RDATA → RESP.
    - SB/SH: merge the WDATA lane into the captured word → WR.
  - WR: MEM_WRITE=1, MEM_ADDRESS=word index, MEM_DATA_IN = full WDATA (SW) or merged word → RESP.
  - RESP: READY=1 for exactly one cycle → IDLE.
- Latency, REQ sampled at edge N:
  - Load: READY at N+3.
  - SW: READY at N+2.
  - SB/SH: READY at N+4.
  - Error: READY at N+1.
- Strobe rules:
  - MEM_READ and MEM_WRITE are never high together.
  - Both are low in IDLE and RESP.
  - MEM_DATA_IN holds its last value outside WR.
- Lane extraction:
  - LB: byte at lane, sign-extended bit 7.
  - LBU: same byte, zero-extended.
  - LH: half at lane[1], sign-extended bit 15.
  - LHU: same half, zero-extended.
  - LW: unchanged.
- RMW merge: only the addressed byte or half is replaced; the other bits come from the read word.
- RDATA holds its value until the next load completes; error responses clear it to 0.

Decomposition:
- Shared package dmem_pkg:
  - State enum (IDLE, RD, RD_WAIT, WR, RESP).
  - FUNCT3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU.
  - misaligned() function.
- Sub-module dmem_lane_align, purely combinational:
  - Inputs: word, lane, funct3, store data.
  - Outputs: extended load value and merged store word.
  - Shared by the load and RMW paths.

Test Plan:
- RAM[5]=0x8899AABB; LB ADDR=0x15 → READY at N+3, RDATA=0xFFFFFFAA, ERROR=0; LBU same address → 0x000000AA.
- RAM[2]=0x11223344; SH ADDR=0x0A, WDATA=0x0000BEEF → MEM_READ at N+1, MEM_WRITE at N+3 with MEM_DATA_IN=0xBEEF3344; READY at N+4.
- SW ADDR=0x0C, WDATA=0xDEADBEEF → MEM_WRITE at N+1, MEM_ADDRESS=3; then LW ADDR=0x0C → RDATA=0xDEADBEEF.
- LW ADDR=0x06, then SH ADDR=0x03, then load FUNCT3=011 → each gives READY+ERROR at N+1, RDATA=0, no memory strobes.
- Assert RESET during the WR state of an SB → MEM_WRITE drops immediately, target RAM word unchanged, no READY, state IDLE.
- Hold REQ high with new ADDR while BUSY → only the first request is executed; exactly one READY pulse per accepted request.
